// File: rtl/mem_loader_pkg.sv
// Shared loader definitions: memory geometry, loader state encoding and the
// held-byte payload used while the loader is busy writing.
package mem_loader_pkg;

  localparam int unsigned MEM_ADDR_W     = 8;
  localparam int unsigned MEM_DATA_W     = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;

  // Loader FSM encoding (kept as plain constants for legacy users of the map)
  localparam logic [1:0] LD_IDLE    = 2'd0;
  localparam logic [1:0] LD_COLLECT = 2'd1;
  localparam logic [1:0] LD_WRITE   = 2'd2;
  localparam logic [1:0] LD_ADVANCE = 2'd3;

  // A byte pulse that arrived while the loader could not accept it
  typedef struct packed {
    logic              valid;
    logic [BYTE_W-1:0] data;
  } byte_hold_t;

endpackage

// File: rtl/mem_loader_button_debounce.sv
// button_debounce: synchronizes a raw push-button and accepts a new level
// only after it has been stable for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   raw         - asynchronous button input, high = pressed
//   level       - debounced (accepted) button level
//   rise_pulse  - one-cycle pulse on each accepted 0->1 transition
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer followed by a stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_1     <= raw;
      sync_2     <= sync_1;
      rise_pulse <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        level      <= sync_2;
        rise_pulse <= sync_2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: assembles 32-bit words from switch bytes latched by a debounced
// button and writes them to MEMORY at an auto-incrementing address.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   enable     - loader mode; 1 = loader owns the memory bus
//   sw_data    - switch byte
//   btn_byte   - raw button: latch sw_data as the next byte of the word
//   btn_addr   - raw button: load sw_data as the write address
//   mem_addr   - write address to MEMORY
//   mem_din    - assembled word to MEMORY
//   mem_we     - one-cycle write strobe
//   busy       - loader is out of IDLE; top level selects the loader's bus
//   byte_idx   - bytes collected in the current word
//   disp_word  - partial word for the hex display
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W          = MEM_ADDR_W,
  parameter int unsigned DATA_W          = MEM_DATA_W,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [BYTE_W-1:0] sw_data,
  input  logic              btn_byte,
  input  logic              btn_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic [IDX_W-1:0]  byte_idx,
  output logic [DATA_W-1:0] disp_word
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

  logic byte_pulse;
  logic addr_pulse;
  logic byte_level;
  logic addr_level;
  logic unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_byte_db (
    .clk        (clk),
    .rst        (rst),
    .raw        (btn_byte),
    .level      (byte_level),
    .rise_pulse (byte_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_addr_db (
    .clk        (clk),
    .rst        (rst),
    .raw        (btn_addr),
    .level      (addr_level),
    .rise_pulse (addr_pulse)
  );

  assign unused_levels = byte_level ^ addr_level;

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] word_q,   word_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic              we_q,     we_d;
  logic              busy_q,   busy_d;
  byte_hold_t        hold_q,   hold_d;

  logic              byte_ev;
  logic [BYTE_W-1:0] byte_val;

  // A byte held over from WRITE/ADVANCE is applied first on return to COLLECT
  assign byte_ev  = byte_pulse | hold_q.valid;
  assign byte_val = hold_q.valid ? hold_q.data : sw_data;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    hold_d  = hold_q;

    case (state_q)
      LD_IDLE: begin
        hold_d = '0;
        if (enable) begin
          state_d = LD_COLLECT;
          idx_d   = '0;
          word_d  = '0;
        end
      end

      LD_COLLECT: begin
        hold_d = '0;
        if (!enable) begin
          // Partial word is discarded; the address is kept
          state_d = LD_IDLE;
          idx_d   = '0;
          word_d  = '0;
        end else if (addr_pulse) begin
          // Address button wins over a coincident byte
          addr_d = sw_data;
          idx_d  = '0;
          word_d = '0;
        end else if (byte_ev) begin
          word_d[BYTE_W*int'(idx_q) +: BYTE_W] = byte_val;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = LD_WRITE;
            we_d    = 1'b1;
          end
        end
      end

      LD_WRITE: begin
        // Write strobe is high for this single cycle; it always completes
        state_d = LD_ADVANCE;
        if (byte_pulse) begin
          hold_d = '{valid: 1'b1, data: sw_data};
        end
      end

      LD_ADVANCE: begin
        addr_d = addr_q + ADDR_W'(1);
        idx_d  = '0;
        word_d = '0;
        if (byte_pulse) begin
          hold_d = '{valid: 1'b1, data: sw_data};
        end
        if (enable) begin
          state_d = LD_COLLECT;
        end else begin
          state_d = LD_IDLE;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase

    busy_d = (state_d != LD_IDLE);
  end

  assign mem_addr  = addr_q;
  assign mem_din   = word_q;
  assign mem_we    = we_q;
  assign busy      = busy_q;
  assign byte_idx  = idx_q;
  assign disp_word = word_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a scoreboard queue holds the expected
// (address, word) of every write; a monitor pops and compares on each mem_we.
module tb_mem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DB     = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [7:0]        sw_data;
  logic              btn_byte;
  logic              btn_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              busy;
  logic [1:0]        byte_idx;
  logic [DATA_W-1:0] disp_word;

  int errors = 0;
  int checks = 0;
  wr_t sb[$];

  mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sw_data   (sw_data),
    .btn_byte  (btn_byte),
    .btn_addr  (btn_addr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .busy      (busy),
    .byte_idx  (byte_idx),
    .disp_word (disp_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 64'(mem_addr), 64'hFFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_din), 64'(e.data));
      end
    end
  end

  task automatic press(input logic is_addr, input logic [7:0] val);
    sw_data = val;
    if (is_addr) btn_addr = 1'b1; else btn_byte = 1'b1;
    repeat (8) @(negedge clk);
    btn_addr = 1'b0;
    btn_byte = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.data = w;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      press(1'b0, tmp[7:0]);
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; enable = 1'b0; sw_data = '0; btn_byte = 1'b0; btn_addr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr", 64'(mem_addr), 64'h0);
    check("rst_din", 64'(mem_din), 64'h0);
    check("rst_we", 64'(mem_we), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_idx", 64'(byte_idx), 64'h0);
    check("rst_disp", 64'(disp_word), 64'h0);

    // 1: basic word write
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("en_busy", 64'(busy), 64'h1);
    press(1'b1, 8'h10);
    check("t1_addr", 64'(mem_addr), 64'h10);
    press(1'b0, 8'h01);
    check("t1_idx1", 64'(byte_idx), 64'h1);
    check("t1_disp1", 64'(disp_word), 64'h01);
    sb.push_back('{addr: 8'h10, data: 32'h04030201});
    press(1'b0, 8'h02);
    press(1'b0, 8'h03);
    press(1'b0, 8'h04);
    check("t1_addr_inc", 64'(mem_addr), 64'h11);
    check("t1_idx0", 64'(byte_idx), 64'h0);
    check("t1_sb_empty", 64'(sb.size()), 64'h0);

    // 2: glitch rejection and exact latency
    sw_data = 8'hAA;
    btn_byte = 1'b1;
    repeat (3) @(negedge clk);
    btn_byte = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_glitch_idx", 64'(byte_idx), 64'h0);
    btn_byte = 1'b1;
    repeat (2 + DB) @(negedge clk);
    check("t2_pre_pulse_idx", 64'(byte_idx), 64'h0);
    @(negedge clk);
    check("t2_post_pulse_idx", 64'(byte_idx), 64'h1);
    check("t2_disp", 64'(disp_word), 64'hAA);
    btn_byte = 1'b0;
    repeat (8) @(negedge clk);

    // 3: address wrap
    press(1'b1, 8'hFF);
    check("t3_addr_ff", 64'(mem_addr), 64'hFF);
    check("t3_idx_clr", 64'(byte_idx), 64'h0);
    send_word(8'hFF, 32'hDEADBEEF);
    check("t3_wrap", 64'(mem_addr), 64'h00);
    send_word(8'h00, 32'hCAFEF00D);
    check("t3_addr_01", 64'(mem_addr), 64'h01);

    // 4: disable mid-word discards partial word, keeps address
    press(1'b0, 8'h55);
    press(1'b0, 8'h66);
    check("t4_idx2", 64'(byte_idx), 64'h2);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_busy", 64'(busy), 64'h0);
    check("t4_idx", 64'(byte_idx), 64'h0);
    check("t4_disp", 64'(disp_word), 64'h0);
    check("t4_addr", 64'(mem_addr), 64'h01);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    send_word(8'h01, 32'h44332211);
    check("t4_addr_02", 64'(mem_addr), 64'h02);

    // 5: coincident byte and address presses
    press(1'b0, 8'h77);
    sw_data = 8'h20;
    btn_byte = 1'b1;
    btn_addr = 1'b1;
    repeat (8) @(negedge clk);
    btn_byte = 1'b0;
    btn_addr = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_addr", 64'(mem_addr), 64'h20);
    check("t5_idx", 64'(byte_idx), 64'h0);
    check("t5_disp", 64'(disp_word), 64'h0);

    // 6: reset during WRITE
    sb.push_back('{addr: 8'h20, data: 32'h0D0C0B0A});
    press(1'b0, 8'h0A);
    press(1'b0, 8'h0B);
    press(1'b0, 8'h0C);
    sw_data = 8'h0D;
    btn_byte = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_we === 1'b1) seen = 1'b1;
    end
    check("t6_we_seen", 64'(seen), 64'h1);
    rst = 1'b1;
    btn_byte = 1'b0;
    @(negedge clk);
    check("t6_we", 64'(mem_we), 64'h0);
    check("t6_addr", 64'(mem_addr), 64'h0);
    check("t6_din", 64'(mem_din), 64'h0);
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_idx", 64'(byte_idx), 64'h0);
    check("t6_disp", 64'(disp_word), 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
